// File: rtl/sys_ctrl_burst_if.sv
// Bus bundle between sys_ctrl_burst and its UART, register file and ALU peers.
// master = controller side, slave = peripheral side.
interface sys_ctrl_burst_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int ALU_OUT_W  = 16
);
    logic [DATA_WIDTH-1:0] UART_RX_DATA;
    logic                  UART_RX_VLD;
    logic                  FIFO_FULL;
    logic [DATA_WIDTH-1:0] UART_TX_DATA;
    logic                  UART_TX_VLD;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [RF_ADDR-1:0]    RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic [DATA_WIDTH-1:0] RF_RdData;
    logic                  RF_RdData_Valid;
    logic                  ALU_EN;
    logic [3:0]            ALU_FUN;
    logic [ALU_OUT_W-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic                  CLKG_EN;
    logic                  CLKDIV_EN;
    logic                  ERR;

    modport master (
        input  UART_RX_DATA, UART_RX_VLD, FIFO_FULL,
        input  RF_RdData, RF_RdData_Valid,
        input  ALU_OUT, ALU_OUT_VLD,
        output UART_TX_DATA, UART_TX_VLD,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN, ERR
    );

    modport slave (
        output UART_RX_DATA, UART_RX_VLD, FIFO_FULL,
        output RF_RdData, RF_RdData_Valid,
        output ALU_OUT, ALU_OUT_VLD,
        input  UART_TX_DATA, UART_TX_VLD,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN, ERR
    );
endinterface

// File: rtl/sys_ctrl_burst.sv
// REF_CLK-domain command controller: UART frames -> RF/ALU -> TX FIFO, with bursts.
// Define SYS_CTRL_TIMEOUT_EN to enable the inter-byte timeout and the ERR pulse.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH  = 8,
    parameter int RF_ADDR     = 4,
    parameter int ALU_OUT_W   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    sys_ctrl_burst_if.master bus
);
    localparam int NBYTES = ALU_OUT_W / DATA_WIDTH;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_AB  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CMD_BWR = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] CMD_BRD = DATA_WIDTH'(8'hEF);

    if (ALU_OUT_W % DATA_WIDTH != 0 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("sys_ctrl_burst: invalid parameter set");
    end

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_A, GET_B,
        GET_FUN, RF_RD, RD_WAIT, ALU_WAIT, TX_PUSH
    } state_t;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_BWR, OP_BRD} op_t;

    state_t                state;
    op_t                   op;
    logic [RF_ADDR-1:0]    addr;
    logic [DATA_WIDTH-1:0] len;
    logic [ALU_OUT_W-1:0]  tx_buf;
    logic [CNT_W-1:0]      tx_cnt;
    logic                  alu_go;
    logic                  wr_en;
    logic                  rd_en;
    logic [RF_ADDR-1:0]    rf_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  alu_en;
    logic [3:0]            alu_fun;
    logic                  clkg_en;
    logic [DATA_WIDTH-1:0] rx;
    logic                  rx_vld;

    assign rx     = bus.UART_RX_DATA;
    assign rx_vld = bus.UART_RX_VLD;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err;
    logic             in_get;
    assign in_get = state inside {GET_ADDR, GET_LEN, GET_DATA,
                                  GET_A, GET_B, GET_FUN};
    assign bus.ERR = err;
`else
    assign bus.ERR = 1'b0;
`endif

    // TX strobe is gated live by FIFO_FULL so a byte is never offered to a full FIFO.
    assign bus.UART_TX_VLD  = (state == TX_PUSH) && !bus.FIFO_FULL;
    assign bus.UART_TX_DATA = tx_buf[DATA_WIDTH-1:0];
    assign bus.RF_WrEn      = wr_en;
    assign bus.RF_RdEn      = rd_en;
    assign bus.RF_Address   = rf_addr;
    assign bus.RF_WrData    = wr_data;
    assign bus.ALU_EN       = alu_en;
    assign bus.ALU_FUN      = alu_fun;
    assign bus.CLKG_EN      = clkg_en;
    assign bus.CLKDIV_EN    = 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            op      <= OP_WR;
            addr    <= '0;
            len     <= '0;
            tx_buf  <= '0;
            tx_cnt  <= '0;
            alu_go  <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            rf_addr <= '0;
            wr_data <= '0;
            alu_en  <= 1'b0;
            alu_fun <= '0;
            clkg_en <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            tmo_cnt <= '0;
            err     <= 1'b0;
`endif
        end else begin
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            alu_en <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            err    <= 1'b0;
`endif
            unique case (state)
                IDLE: if (rx_vld) begin
                    case (rx)
                        CMD_WR:  begin op <= OP_WR;  state <= GET_ADDR; end
                        CMD_RD:  begin op <= OP_RD;  state <= GET_ADDR; end
                        CMD_BWR: begin op <= OP_BWR; state <= GET_ADDR; end
                        CMD_BRD: begin op <= OP_BRD; state <= GET_ADDR; end
                        CMD_AB:  state <= GET_A;
                        CMD_ALU: state <= GET_FUN;
                        default: state <= IDLE;
                    endcase
                end
                GET_ADDR: if (rx_vld) begin
                    addr <= rx[RF_ADDR-1:0];
                    len  <= ONE;
                    case (op)
                        OP_WR:   state <= GET_DATA;
                        OP_RD:   state <= RF_RD;
                        default: state <= GET_LEN;
                    endcase
                end
                GET_LEN: if (rx_vld) begin
                    len <= rx;
                    if (rx == '0)
                        state <= IDLE;
                    else if (op == OP_BRD)
                        state <= RF_RD;
                    else
                        state <= GET_DATA;
                end
                GET_DATA: if (rx_vld) begin
                    wr_en   <= 1'b1;
                    rf_addr <= addr;
                    wr_data <= rx;
                    addr    <= addr + 1'b1;
                    len     <= len - 1'b1;
                    if (len == ONE)
                        state <= IDLE;
                end
                GET_A: if (rx_vld) begin
                    wr_en   <= 1'b1;
                    rf_addr <= '0;
                    wr_data <= rx;
                    state   <= GET_B;
                end
                GET_B: if (rx_vld) begin
                    wr_en   <= 1'b1;
                    rf_addr <= RF_ADDR'(1);
                    wr_data <= rx;
                    state   <= GET_FUN;
                end
                GET_FUN: if (rx_vld) begin
                    alu_fun <= rx[3:0];
                    clkg_en <= 1'b1;
                    alu_go  <= 1'b1;
                    len     <= ONE;
                    state   <= ALU_WAIT;
                end
                ALU_WAIT: begin
                    // ALU_EN fires one cycle after the clock gate opens
                    if (alu_go) begin
                        alu_en <= 1'b1;
                        alu_go <= 1'b0;
                    end else if (bus.ALU_OUT_VLD) begin
                        tx_buf  <= bus.ALU_OUT;
                        tx_cnt  <= CNT_W'(NBYTES);
                        clkg_en <= 1'b0;
                        state   <= TX_PUSH;
                    end
                end
                RF_RD: begin
                    rd_en   <= 1'b1;
                    rf_addr <= addr;
                    state   <= RD_WAIT;
                end
                RD_WAIT: if (bus.RF_RdData_Valid) begin
                    tx_buf <= ALU_OUT_W'(bus.RF_RdData);
                    tx_cnt <= CNT_W'(1);
                    state  <= TX_PUSH;
                end
                TX_PUSH: if (!bus.FIFO_FULL) begin
                    tx_buf <= tx_buf >> DATA_WIDTH;
                    tx_cnt <= tx_cnt - 1'b1;
                    if (tx_cnt == CNT_W'(1)) begin
                        if (len == ONE) begin
                            state <= IDLE;
                        end else begin
                            len   <= len - 1'b1;
                            addr  <= addr + 1'b1;
                            state <= RF_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SYS_CTRL_TIMEOUT_EN
            if (rx_vld || !in_get) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_cnt <= '0;
                err     <= 1'b1;
                state   <= IDLE;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Scoreboard bench for sys_ctrl_burst: frame-level reference model fills
// expectation queues, a negedge monitor pops them as the DUT responds.
module tb_sys_ctrl_burst;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int OW  = 16;
    localparam int TMO = 1024;
    localparam int NB  = OW / DW;
    localparam int NRF = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sys_ctrl_burst_if #(.DATA_WIDTH(DW), .RF_ADDR(AW), .ALU_OUT_W(OW)) bus ();

    sys_ctrl_burst #(
        .DATA_WIDTH(DW), .RF_ADDR(AW), .ALU_OUT_W(OW), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_err  = 0;
    bit force_full = 1'b0;

    logic [DW-1:0] ref_rf [NRF] = '{default: '0};
    logic [DW-1:0] env_rf [NRF] = '{default: '0};
    int alu_lat = 0;

    logic [DW-1:0] exp_tx [$];
    int            exp_wa [$];
    logic [DW-1:0] exp_wd [$];
    int            exp_ra [$];
    logic [3:0]    exp_fun[$];

    function automatic logic [OW-1:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0:    return OW'(a) + OW'(b);
            4'd1:    return OW'(a) - OW'(b);
            4'd2:    return OW'(a) * OW'(b);
            4'd3:    return OW'(a & b);
            4'd4:    return OW'(a | b);
            4'd5:    return OW'(a ^ b);
            default: return {a, b};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event value %0h at %0t", name, act, $time);
    endtask

    // Register file peer: one-cycle registered read
    always @(posedge clk) begin
        bus.RF_RdData_Valid <= bus.RF_RdEn;
        if (bus.RF_RdEn) bus.RF_RdData <= env_rf[bus.RF_Address];
        if (bus.RF_WrEn) env_rf[bus.RF_Address] <= bus.RF_WrData;
    end

    // ALU peer with random latency
    always @(posedge clk) begin
        bus.ALU_OUT_VLD <= 1'b0;
        if (bus.ALU_EN) begin
            alu_lat <= int'($urandom_range(1, 4));
        end else if (alu_lat == 1) begin
            bus.ALU_OUT_VLD <= 1'b1;
            bus.ALU_OUT     <= alu_f(env_rf[0], env_rf[1], bus.ALU_FUN);
            alu_lat         <= 0;
        end else if (alu_lat > 1) begin
            alu_lat <= alu_lat - 1;
        end
    end

    initial begin
        bus.FIFO_FULL = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.FIFO_FULL = force_full ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.UART_TX_VLD) begin
                    check("tx_vld_while_full", bus.FIFO_FULL, 0);
                    check("clkg_during_tx", bus.CLKG_EN, 0);
                    if (exp_tx.size() == 0) unexpected("tx_extra", bus.UART_TX_DATA);
                    else check("tx_data", bus.UART_TX_DATA, exp_tx.pop_front());
                end
                if (bus.RF_WrEn) begin
                    if (exp_wa.size() == 0) unexpected("wr_extra", bus.RF_Address);
                    else begin
                        check("wr_addr", bus.RF_Address, exp_wa.pop_front());
                        check("wr_data", bus.RF_WrData, exp_wd.pop_front());
                    end
                end
                if (bus.RF_RdEn) begin
                    if (exp_ra.size() == 0) unexpected("rd_extra", bus.RF_Address);
                    else check("rd_addr", bus.RF_Address, exp_ra.pop_front());
                end
                if (bus.ALU_EN) begin
                    check("clkg_at_alu_en", bus.CLKG_EN, 1);
                    if (exp_fun.size() == 0) unexpected("alu_extra", bus.ALU_FUN);
                    else check("alu_fun", bus.ALU_FUN, exp_fun.pop_front());
                end
                if (bus.ERR) err_seen++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] b);
        bus.UART_RX_DATA = b;
        bus.UART_RX_VLD  = 1'b1;
        tick();
        bus.UART_RX_VLD  = 1'b0;
        bus.UART_RX_DATA = DW'($urandom);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    function automatic logic [DW-1:0] abyte(input int a);
        logic [DW-1:0] b;
        b = DW'($urandom);
        b[AW-1:0] = AW'(a);
        return b;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while ((exp_tx.size() + exp_wa.size() + exp_ra.size() + exp_fun.size()) != 0
               && n < 3000) begin
            tick();
            n++;
        end
        check("drain_timeout", n >= 3000, 0);
        repeat (2) tick();
    endtask

    task automatic push_wr(input int a, input logic [DW-1:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
        ref_rf[a] = d;
    endtask

    task automatic f_write(input int a, input logic [DW-1:0] d);
        push_wr(a, d);
        send(8'hAA); send(abyte(a)); send(d);
        drain();
    endtask

    task automatic f_read(input int a);
        exp_ra.push_back(a);
        exp_tx.push_back(ref_rf[a]);
        send(8'hBB); send(abyte(a));
        drain();
    endtask

    task automatic push_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [3:0] f);
        logic [OW-1:0] r;
        r = alu_f(a, b, f);
        exp_fun.push_back(f);
        for (int k = 0; k < NB; k++) exp_tx.push_back(DW'(r >> (k * DW)));
    endtask

    task automatic f_ab(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] fb);
        push_wr(0, a);
        push_wr(1, b);
        push_alu(a, b, fb[3:0]);
        send(8'hCC); send(a); send(b); send(fb);
        drain();
    endtask

    task automatic f_alu(input logic [DW-1:0] fb);
        push_alu(ref_rf[0], ref_rf[1], fb[3:0]);
        send(8'hDD); send(fb);
        drain();
    endtask

    task automatic f_bwrite(input int a, input logic [DW-1:0] d[$]);
        for (int i = 0; i < d.size(); i++) push_wr((a + i) % NRF, d[i]);
        send(8'hEE); send(abyte(a)); send(DW'(d.size()));
        foreach (d[i]) send(d[i]);
        drain();
    endtask

    task automatic push_bread(input int a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ra.push_back((a + i) % NRF);
            exp_tx.push_back(ref_rf[(a + i) % NRF]);
        end
    endtask

    task automatic f_bread(input int a, input int n);
        push_bread(a, n);
        send(8'hEF); send(abyte(a)); send(DW'(n));
        drain();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_vld"},  bus.UART_TX_VLD, 0);
        check({tag, "_tx_data"}, bus.UART_TX_DATA, 0);
        check({tag, "_wren"},    bus.RF_WrEn, 0);
        check({tag, "_rden"},    bus.RF_RdEn, 0);
        check({tag, "_addr"},    bus.RF_Address, 0);
        check({tag, "_wdata"},   bus.RF_WrData, 0);
        check({tag, "_alu_en"},  bus.ALU_EN, 0);
        check({tag, "_alu_fun"}, bus.ALU_FUN, 0);
        check({tag, "_clkg"},    bus.CLKG_EN, 0);
        check({tag, "_clkdiv"},  bus.CLKDIV_EN, 1);
        check({tag, "_err"},     bus.ERR, 0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] b;
        int a;
        int n;
        bus.UART_RX_VLD  = 1'b0;
        bus.UART_RX_DATA = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        f_write(5, 8'h3C);
        f_read(5);
        f_ab(8'h0A, 8'h03, 8'h00);
        q = '{8'h11, 8'h22, 8'h33};
        f_bwrite(14, q);
        f_bread(14, 3);

        push_bread(0, 4);
        send(8'hEF); send(8'h00); send(8'h04);
        force_full = 1'b1;
        repeat (10) tick();
        force_full = 1'b0;
        drain();

        send(8'h55);
        repeat (4) tick();
        send(8'hEE); send(8'h00); send(8'h00);
        drain();

        f_write(7, 8'hAA);
        f_read(7);
        f_alu(8'h02);

        // Reset in the middle of a burst keeps the bytes already written
        push_wr(3, 8'h5A);
        push_wr(4, 8'hA5);
        send(8'hEE); send(8'h03); send(8'h04); send(8'h5A); send(8'hA5);
        repeat (3) tick();
        check("partial_burst_writes", exp_wa.size(), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        f_bread(3, 4);

`ifdef SYS_CTRL_TIMEOUT_EN
        send(8'hAA); send(8'h02);
        repeat (TMO + 10) tick();
        exp_err = 1;
        f_write(2, 8'h7F);
        f_read(2);
`endif

        for (int it = 0; it < 40; it++) begin
            a = int'($urandom_range(0, NRF - 1));
            case ($urandom_range(0, 6))
                0: f_write(a, DW'($urandom));
                1: f_read(a);
                2: f_ab(DW'($urandom), DW'($urandom), DW'($urandom_range(0, 7)));
                3: f_alu(DW'($urandom));
                4: begin
                    n = int'($urandom_range(0, 6));
                    q = {};
                    for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
                    f_bwrite(a, q);
                end
                5: f_bread(a, int'($urandom_range(0, 6)));
                default: begin
                    do b = DW'($urandom);
                    while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hEF});
                    send(b);
                    drain();
                end
            endcase
        end

        repeat (5) tick();
        check("err_pulses", err_seen, exp_err);
        check("leftover_tx", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
